pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_pkg.sv | 30 +++
 rtl/pipe_skid_buf.sv | 42 ++++
 rtl/pipe_stage_reg.sv | 106 ++++++++++
 tb/tb_pipe_stage_reg.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register: lane indices, default widths
// and control-bundle field offsets.
package pipe_pkg;

    localparam int DEF_CTRL_W = 12;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_NLANE  = 5;
    localparam int DEF_CNT_W  = 16;

    typedef enum logic [2:0] {
        LANE_BUSA  = 3'd0,
        LANE_BUSB  = 3'd1,
        LANE_INST  = 3'd2,
        LANE_IMM32 = 3'd3,
        LANE_PC    = 3'd4
    } lane_e;

    // Bit offsets of the fields inside the control bundle
    localparam int CTRL_MEMTOREG = 0;
    localparam int CTRL_MEMWR    = 1;
    localparam int CTRL_REGWR    = 2;
    localparam int CTRL_REGDST   = 3;
    localparam int CTRL_ALUSRC   = 4;
    localparam int CTRL_ALUCTR   = 5;
    localparam int CTRL_ALUCTR_W = 4;
    localparam int CTRL_BRANCH   = 9;
    localparam int CTRL_JUMP     = 10;
    localparam int CTRL_EXTOP    = 11;

endpackage

// File: rtl/pipe_skid_buf.sv
// One-entry skid buffer (valid, ctrl, data) that catches an input accepted while the
// stage output is held. Only built when PIPE_SKID_EN is defined.
`ifdef PIPE_SKID_EN
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int CTRL_W = DEF_CTRL_W,
    parameter int DW     = DEF_DATA_W * DEF_NLANE
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              flush,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [CTRL_W-1:0] wr_ctrl,
    input  logic [DW-1:0]     wr_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DW-1:0]     data
);

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            ctrl  <= '0;
            data  <= '0;
        end else if (flush) begin
            valid <= 1'b0;
            ctrl  <= '0;
            data  <= '0;
        end else if (wr_en) begin
            valid <= 1'b1;
            ctrl  <= wr_ctrl;
            data  <= wr_data;
        end else if (rd_en) begin
            valid <= 1'b0;
            ctrl  <= '0;
        end
    end

endmodule
`endif

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with flush/stall control, valid/ready handshake and
// saturating stall/bubble counters. Define PIPE_SKID_EN to add a one-entry skid buffer.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = DEF_CTRL_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int NLANE  = DEF_NLANE,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                    CLK,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [CTRL_W-1:0]       in_ctrl,
    input  logic [DATA_W*NLANE-1:0] in_data,
    input  logic                    flush,
    input  logic                    stall,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CTRL_W-1:0]       out_ctrl,
    output logic [DATA_W*NLANE-1:0] out_data,
    output logic [CNT_W-1:0]        stall_cnt,
    output logic [CNT_W-1:0]        bubble_cnt
);

    localparam int DW = DATA_W * NLANE;

    logic              accept;
    logic              load;
    logic              bubble;
    logic [CTRL_W-1:0] nxt_ctrl;
    logic [DW-1:0]     nxt_data;

`ifdef PIPE_SKID_EN
    logic              skid_valid;
    logic              skid_wr;
    logic              skid_rd;
    logic              drain;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DW-1:0]     skid_data;

    // in_ready depends only on the skid register plus the hazard inputs
    assign in_ready = reset & (flush | (~skid_valid & ~stall));
    assign accept   = in_valid & in_ready & ~flush & ~stall;
    assign drain    = ~out_valid | out_ready;
    assign skid_wr  = accept & ~drain;
    assign skid_rd  = ~flush & ~stall & drain & skid_valid;
    assign load     = ~flush & ~stall & drain & (skid_valid | accept);
    // A full skid entry is older than anything on the input, so it goes first
    assign nxt_ctrl = skid_valid ? skid_ctrl : in_ctrl;
    assign nxt_data = skid_valid ? skid_data : in_data;

    pipe_skid_buf #(
        .CTRL_W (CTRL_W),
        .DW     (DW)
    ) u_skid (
        .CLK     (CLK),
        .reset   (reset),
        .flush   (flush),
        .wr_en   (skid_wr),
        .rd_en   (skid_rd),
        .wr_ctrl (in_ctrl),
        .wr_data (in_data),
        .valid   (skid_valid),
        .ctrl    (skid_ctrl),
        .data    (skid_data)
    );
`else
    assign in_ready = reset & (flush | (~stall & (out_ready | ~out_valid)));
    assign accept   = in_valid & in_ready & ~flush;
    assign load     = accept;
    assign nxt_ctrl = in_ctrl;
    assign nxt_data = in_data;
`endif

    assign bubble = ~flush & ~stall & out_ready & ~load;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            out_valid  <= 1'b0;
            out_ctrl   <= '0;
            out_data   <= '0;
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_ctrl  <= '0;
            out_data  <= '0;
        end else if (stall) begin
            if (stall_cnt != {CNT_W{1'b1}})
                stall_cnt <= stall_cnt + 1'b1;
        end else if (load) begin
            out_valid <= 1'b1;
            out_ctrl  <= nxt_ctrl;
            out_data  <= nxt_data;
        end else if (bubble) begin
            // Bubble keeps the lanes but zeroes ctrl so nothing downstream writes
            out_valid <= 1'b0;
            out_ctrl  <= '0;
            if (bubble_cnt != {CNT_W{1'b1}})
                bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: table-driven flow/flush/stall vectors plus
// hand-written back-pressure, saturation and mid-stream reset sequences.
module tb_pipe_stage_reg;

    localparam int CTRL_W = 12;
    localparam int DATA_W = 32;
    localparam int NLANE  = 5;
    localparam int CNT_W  = 4;
    localparam int DW     = DATA_W * NLANE;

    logic              CLK;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DW-1:0]     in_data;
    logic              flush;
    logic              stall;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DW-1:0]     out_data;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  bubble_cnt;

    int checks;
    int failures;

    pipe_stage_reg #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W),
        .NLANE  (NLANE),
        .CNT_W  (CNT_W)
    ) dut (
        .CLK        (CLK),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ctrl    (in_ctrl),
        .in_data    (in_data),
        .flush      (flush),
        .stall      (stall),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ctrl   (out_ctrl),
        .out_data   (out_data),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic              iv;
        logic [CTRL_W-1:0] ctrl;
        int unsigned       dseed;
        logic              fl;
        logic              st;
        logic              ordy;
        logic              e_irdy;
        logic              e_ov;
        logic [CTRL_W-1:0] e_ctrl;
        int unsigned       e_dseed;
        int unsigned       e_bub;
        int unsigned       e_stl;
    } vec_t;

    localparam int NV = 15;
    vec_t tbl [NV];

    // Seed 0 stands for all-zero lanes; otherwise each lane gets a distinct word
    function automatic logic [DW-1:0] mkdata(input int unsigned s);
        logic [DW-1:0] d;
        d = '0;
        if (s != 0)
            for (int i = 0; i < NLANE; i++)
                d[i*DATA_W +: DATA_W] = s + i * 32'h1000;
        return d;
    endfunction

    function automatic vec_t v(input logic iv, input logic [CTRL_W-1:0] c, input int unsigned ds,
                               input logic fl, input logic st, input logic ordy,
                               input logic e_irdy, input logic e_ov, input logic [CTRL_W-1:0] e_c,
                               input int unsigned e_ds, input int unsigned e_bub, input int unsigned e_stl);
        vec_t r;
        r.iv = iv; r.ctrl = c; r.dseed = ds; r.fl = fl; r.st = st; r.ordy = ordy;
        r.e_irdy = e_irdy; r.e_ov = e_ov; r.e_ctrl = e_c; r.e_dseed = e_ds;
        r.e_bub = e_bub; r.e_stl = e_stl;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_out(input string nm, input logic ov, input logic [CTRL_W-1:0] c, input int unsigned ds);
        chk({nm, " out_valid"}, DW'(out_valid), DW'(ov));
        chk({nm, " out_ctrl"}, DW'(out_ctrl), DW'(c));
        chk({nm, " out_data"}, out_data, mkdata(ds));
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0;
        flush = 1'b0; stall = 1'b0; out_ready = 1'b0;

        //            iv ctrl    seed fl st or | irdy ov ctrl    seed bub stl
        tbl[0]  = v(1, 12'h0A5, 100, 0, 0, 1,   1, 1, 12'h0A5, 100, 0, 0);
        tbl[1]  = v(1, 12'h0A5, 101, 0, 0, 1,   1, 1, 12'h0A5, 101, 0, 0);
        tbl[2]  = v(1, 12'h0A5, 102, 0, 0, 1,   1, 1, 12'h0A5, 102, 0, 0);
        tbl[3]  = v(1, 12'h0A5, 103, 0, 0, 1,   1, 1, 12'h0A5, 103, 0, 0);
        tbl[4]  = v(1, 12'h0A5, 104, 0, 0, 1,   1, 1, 12'h0A5, 104, 0, 0);
        tbl[5]  = v(1, 12'h03C, 200, 1, 0, 1,   1, 0, 12'h000,   0, 0, 0);
        tbl[6]  = v(1, 12'h05A, 300, 0, 0, 1,   1, 1, 12'h05A, 300, 0, 0);
        tbl[7]  = v(0, 12'h000,   0, 0, 0, 1,   1, 0, 12'h000, 300, 1, 0);
        tbl[8]  = v(0, 12'h000,   0, 0, 0, 0,   1, 0, 12'h000, 300, 1, 0);
        tbl[9]  = v(1, 12'h0F0, 400, 0, 0, 0,   1, 1, 12'h0F0, 400, 1, 0);
        tbl[10] = v(1, 12'h111, 500, 0, 1, 1,   0, 1, 12'h0F0, 400, 1, 1);
        tbl[11] = v(1, 12'h111, 500, 0, 1, 1,   0, 1, 12'h0F0, 400, 1, 2);
        tbl[12] = v(1, 12'h111, 500, 0, 1, 1,   0, 1, 12'h0F0, 400, 1, 3);
        tbl[13] = v(1, 12'h111, 500, 0, 0, 1,   1, 1, 12'h111, 500, 1, 3);
        tbl[14] = v(1, 12'h222, 600, 1, 1, 0,   1, 0, 12'h000,   0, 1, 3);

        // Reset state, including combinational in_ready held low
        #2;
        chk_out("reset", 1'b0, '0, 0);
        chk("reset stall_cnt", DW'(stall_cnt), '0);
        chk("reset bubble_cnt", DW'(bubble_cnt), '0);
        chk("reset in_ready", DW'(in_ready), '0);
        tick();
        tick();
        reset = 1'b1;

        for (int k = 0; k < NV; k++) begin
            in_valid = tbl[k].iv; in_ctrl = tbl[k].ctrl; in_data = mkdata(tbl[k].dseed);
            flush = tbl[k].fl; stall = tbl[k].st; out_ready = tbl[k].ordy;
            #1;
            chk($sformatf("v%0d in_ready", k), DW'(in_ready), DW'(tbl[k].e_irdy));
            tick();
            chk_out($sformatf("v%0d", k), tbl[k].e_ov, tbl[k].e_ctrl, tbl[k].e_dseed);
            chk($sformatf("v%0d bubble_cnt", k), DW'(bubble_cnt), DW'(tbl[k].e_bub));
            chk($sformatf("v%0d stall_cnt", k), DW'(stall_cnt), DW'(tbl[k].e_stl));
        end

        // Back-pressure: entry A held two cycles while B is offered
        flush = 1'b0; stall = 1'b0;
        in_valid = 1'b1; in_ctrl = 12'h0AA; in_data = mkdata(700); out_ready = 1'b0;
        tick();
        chk_out("bp load A", 1'b1, 12'h0AA, 700);
        in_ctrl = 12'h0BB; in_data = mkdata(800);
        #1;
`ifdef PIPE_SKID_EN
        chk("bp in_ready 1st", DW'(in_ready), DW'(1'b1));
`else
        chk("bp in_ready 1st", DW'(in_ready), DW'(1'b0));
`endif
        tick();
        chk_out("bp hold 1", 1'b1, 12'h0AA, 700);
        chk("bp in_ready 2nd", DW'(in_ready), DW'(1'b0));
        tick();
        chk_out("bp hold 2", 1'b1, 12'h0AA, 700);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
`ifdef PIPE_SKID_EN
        chk_out("bp drain", 1'b1, 12'h0BB, 800);
`else
        chk_out("bp drain", 1'b0, 12'h000, 700);
`endif
        tick();
        chk("bp empty out_valid", DW'(out_valid), DW'(1'b0));
        chk("bp empty out_ctrl", DW'(out_ctrl), '0);
`ifdef PIPE_SKID_EN
        chk("bp bubble_cnt", DW'(bubble_cnt), DW'(2));
`else
        chk("bp bubble_cnt", DW'(bubble_cnt), DW'(3));
`endif

        // Stall saturation: starts at 3, reaches 15 after 12 cycles and stays there
        out_ready = 1'b0; stall = 1'b1;
        for (int i = 0; i < 11; i++) tick();
        chk("sat stall_cnt 14", DW'(stall_cnt), DW'(14));
        tick();
        chk("sat stall_cnt 15", DW'(stall_cnt), DW'(15));
        for (int i = 0; i < 8; i++) tick();
        chk("sat stall_cnt hold", DW'(stall_cnt), DW'(15));
        stall = 1'b0;

        // Mid-stream reset with a valid entry, then a first-edge transfer
        in_valid = 1'b1; in_ctrl = 12'h0CC; in_data = mkdata(900);
        tick();
        chk_out("mid load", 1'b1, 12'h0CC, 900);
        reset = 1'b0;
        #1;
        chk_out("mid reset", 1'b0, '0, 0);
        chk("mid reset stall_cnt", DW'(stall_cnt), '0);
        chk("mid reset bubble_cnt", DW'(bubble_cnt), '0);
        chk("mid reset in_ready", DW'(in_ready), '0);
        tick();
        #2;
        reset = 1'b1;
        in_ctrl = 12'h077; in_data = mkdata(950); out_ready = 1'b1;
        #1;
        chk("post reset in_ready", DW'(in_ready), DW'(1'b1));
        tick();
        chk_out("post reset first", 1'b1, 12'h077, 950);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
